// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_pkg
//  Purpose  : Shared definitions for the memory port arbiter: arbiter state
//             encoding, requester identifiers, wait-cycle range limits and a
//             helper that turns WAIT_CYCLES into the access timer's terminal
//             count.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Arbiter state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_e;

    // Requester identifiers; also the encoding of the last-grant pointer
    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    // Legal range of memory access cycles per transaction
    localparam int unsigned C_WAIT_CYCLES_MIN = 1;
    localparam int unsigned C_WAIT_CYCLES_MAX = 15;

    // Access timer width and memory data width
    localparam int unsigned C_TIMER_W = 4;
    localparam int unsigned C_DATA_W  = 32;

    // Terminal count of the access timer for a given WAIT_CYCLES value.
    // Out-of-range values are clamped to the legal range so the 4-bit
    // counter can never be asked to count past its width.
    function automatic logic [C_TIMER_W-1:0] wait_terminal(input int cycles);
        int unsigned c;
        if (cycles < int'(C_WAIT_CYCLES_MIN)) begin
            c = C_WAIT_CYCLES_MIN;
        end else if (cycles > int'(C_WAIT_CYCLES_MAX)) begin
            c = C_WAIT_CYCLES_MAX;
        end else begin
            c = int'(cycles);
        end
        return C_TIMER_W'(c - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Purpose  : Bundle of the fetch requester, data requester and shared memory
//             signals seen by the memory port arbiter.
//  Ports    : f_*   fetch requester (read only)
//             d_*   data requester (read/write)
//             mem_* shared memory port
//  Modports : slave  - arbiter view (requests/memory read data in,
//                      grants/done/read data/memory strobes out)
//             master - requester/memory environment view (opposite)
//  Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 26
);
    // Fetch requester
    logic                f_req;
    logic [ADDR_W-1:0]   f_addr;
    logic                f_gnt;
    logic                f_done;
    logic [C_DATA_W-1:0] f_rdata;

    // Data requester
    logic                d_req;
    logic                d_we;
    logic [ADDR_W-1:0]   d_addr;
    logic [C_DATA_W-1:0] d_wdata;
    logic                d_gnt;
    logic                d_done;
    logic [C_DATA_W-1:0] d_rdata;

    // Shared memory port
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_read;
    logic                mem_write;
    logic [C_DATA_W-1:0] mem_wdata;
    logic [C_DATA_W-1:0] mem_rdata;

    modport slave (
        input  f_req, f_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output f_gnt, f_done, f_rdata,
        output d_gnt, d_done, d_rdata,
        output mem_addr, mem_read, mem_write, mem_wdata
    );

    modport master (
        output f_req, f_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  f_gnt, f_done, f_rdata,
        input  d_gnt, d_done, d_rdata,
        input  mem_addr, mem_read, mem_write, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_access_timer.sv
`default_nettype none
// ============================================================================
//  Module   : access_timer
//  Purpose  : 4-bit wait counter for the memory access phase. Cleared by
//             load, advanced by en, and saturating at TERMINAL so it can never
//             wrap inside a transaction.
//  Ports    : clk   - system clock
//             rst_n - asynchronous active-low reset
//             load  - clear the count (entering ACCESS)
//             en    - advance the count by one
//             tc    - count has reached TERMINAL
//  Revision : 1.0  initial release
// ============================================================================
module access_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter logic [C_TIMER_W-1:0] TERMINAL = 4'd1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [C_TIMER_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= '0;
        end else if (en && !tc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tc = (r_count == TERMINAL);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Two-requester (fetch/data) round-robin arbiter for a single
//             shared memory port with a fixed WAIT_CYCLES access time.
//             Each transaction runs IDLE -> ACCESS (WAIT_CYCLES) -> DONE.
//  Ports    : clk   - system clock, all state changes on its rising edge
//             rst_n - asynchronous active-low reset
//             bus   - mem_port_arbiter_if.slave (requesters + memory port)
//  Params   : WAIT_CYCLES - memory access cycles per transaction (1..15)
//             ADDR_W      - word address width
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [C_TIMER_W-1:0] c_terminal = wait_terminal(WAIT_CYCLES);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    // Last granted requester; while a transaction is in flight it is also the
    // current owner of the memory port.
    owner_e              r_last;
    owner_e              w_winner;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [C_DATA_W-1:0] r_wdata;
    logic [C_DATA_W-1:0] r_f_rdata;
    logic [C_DATA_W-1:0] r_d_rdata;

    logic w_any_req;
    logic w_grant;
    logic w_timer_load;
    logic w_timer_en;
    logic w_timer_tc;
    logic w_capture;

    assign w_any_req = bus.f_req | bus.d_req;

    // Round-robin pick: on contention the requester that was not granted
    // last wins; a lone request simply wins.
    always_comb begin
        w_winner = OWN_FETCH;
        if (bus.f_req && bus.d_req) begin
            w_winner = (r_last == OWN_DATA) ? OWN_FETCH : OWN_DATA;
        end else if (bus.d_req) begin
            w_winner = OWN_DATA;
        end
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_timer_load = 1'b0;
        w_timer_en   = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt  = ST_ACCESS;
                    w_grant      = 1'b1;
                    w_timer_load = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (w_timer_tc) begin
                    // Last access cycle: memory read data is valid now.
                    w_state_nxt = ST_DONE;
                    w_capture   = ~r_we;
                end else begin
                    w_timer_en = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction registers. The memory port is driven only from these,
    // so requesters may change or drop their inputs after the grant.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last    <= OWN_DATA;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_f_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_last <= w_winner;
                if (w_winner == OWN_DATA) begin
                    r_addr  <= bus.d_addr;
                    r_we    <= bus.d_we;
                    r_wdata <= bus.d_wdata;
                end else begin
                    r_addr  <= bus.f_addr;
                    r_we    <= 1'b0;
                    r_wdata <= '0;
                end
            end
            if (w_capture) begin
                if (r_last == OWN_DATA) begin
                    r_d_rdata <= bus.mem_rdata;
                end else begin
                    r_f_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    access_timer #(
        .TERMINAL (c_terminal)
    ) u_access_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_timer_load),
        .en    (w_timer_en),
        .tc    (w_timer_tc)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.f_gnt     = (r_state != ST_IDLE) && (r_last == OWN_FETCH);
    assign bus.d_gnt     = (r_state != ST_IDLE) && (r_last == OWN_DATA);
    assign bus.f_done    = (r_state == ST_DONE) && (r_last == OWN_FETCH);
    assign bus.d_done    = (r_state == ST_DONE) && (r_last == OWN_DATA);
    assign bus.f_rdata   = r_f_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_read  = (r_state == ST_ACCESS) && !r_we;
    assign bus.mem_write = (r_state == ST_ACCESS) &&  r_we;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter. A WAIT_CYCLES=2
//             instance is driven with directed and random transactions and
//             compared against a transaction-level model (round-robin
//             pointer, expected read data registers). WAIT_CYCLES=1 and 15
//             instances check strobe width and dropped-request completion.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W = 26;
    localparam int W2     = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: last grant (0 fetch, 1 data), expected read data registers
    int          exp_last;
    logic [31:0] exp_f_rdata;
    logic [31:0] exp_d_rdata;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus2  ();
    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus1  ();
    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus15 ();

    mem_port_arbiter #(.WAIT_CYCLES(W2), .ADDR_W(ADDR_W)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave));
    mem_port_arbiter #(.WAIT_CYCLES(1), .ADDR_W(ADDR_W)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    mem_port_arbiter #(.WAIT_CYCLES(15), .ADDR_W(ADDR_W)) u_dut15 (
        .clk(clk), .rst_n(rst_n), .bus(bus15.slave));

    // Memory contents: a fixed function of the address.
    function automatic logic [31:0] mem_fn(input logic [ADDR_W-1:0] a);
        if (a == 26'h0000010) return 32'h20010005;
        return {a[15:0], a[25:10]} ^ 32'hA5C3_0F1E;
    endfunction

    assign bus2.mem_rdata  = mem_fn(bus2.mem_addr);
    assign bus1.mem_rdata  = mem_fn(bus1.mem_addr);
    assign bus15.mem_rdata = mem_fn(bus15.mem_addr);

    // {f_gnt, d_gnt, f_done, d_done, mem_read, mem_write}
    function automatic logic [5:0] st2();
        return {bus2.f_gnt, bus2.d_gnt, bus2.f_done, bus2.d_done,
                bus2.mem_read, bus2.mem_write};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rdata(input string tag);
        check({tag, ".f_rdata"}, 64'(bus2.f_rdata), 64'(exp_f_rdata));
        check({tag, ".d_rdata"}, 64'(bus2.d_rdata), 64'(exp_d_rdata));
    endtask

    // One transaction on the WAIT_CYCLES=2 instance. Called at a negedge
    // while the arbiter is idle; returns at the negedge of the IDLE cycle
    // that follows DONE. With scramble set, requester inputs are randomised
    // every cycle after the grant.
    task automatic run_txn(input logic f, input logic d, input logic we,
                           input logic [ADDR_W-1:0] fa, input logic [ADDR_W-1:0] da,
                           input logic [31:0] wd, input logic scramble);
        int                win;
        logic              is_wr;
        logic [ADDR_W-1:0] ea;
        bus2.f_req = f;  bus2.d_req = d;  bus2.d_we = we;
        bus2.f_addr = fa; bus2.d_addr = da; bus2.d_wdata = wd;
        if (f && d) win = (exp_last == 1) ? 0 : 1;
        else        win = d ? 1 : 0;
        exp_last = win;
        is_wr = (win == 1) && we;
        ea    = (win == 1) ? da : fa;
        for (int c = 1; c <= W2 + 1; c++) begin
            @(posedge clk);
            #1;
            if (scramble) begin
                bus2.f_req   = 1'($urandom_range(0, 1));
                bus2.d_req   = 1'($urandom_range(0, 1));
                bus2.d_we    = 1'($urandom_range(0, 1));
                bus2.f_addr  = ADDR_W'($urandom);
                bus2.d_addr  = ADDR_W'($urandom);
                bus2.d_wdata = $urandom;
            end
            @(negedge clk);
            if (c <= W2) begin
                check("access.status", 64'(st2()),
                      64'({win == 0, win == 1, 1'b0, 1'b0, !is_wr, is_wr}));
                check("access.mem_addr", 64'(bus2.mem_addr), 64'(ea));
                if (is_wr) check("access.mem_wdata", 64'(bus2.mem_wdata), 64'(wd));
            end else begin
                if (!is_wr) begin
                    if (win == 1) exp_d_rdata = mem_fn(ea);
                    else          exp_f_rdata = mem_fn(ea);
                end
                check("done.status", 64'(st2()),
                      64'({win == 0, win == 1, win == 0, win == 1, 1'b0, 1'b0}));
            end
            check_rdata("txn");
        end
        @(posedge clk);
        #1;
        bus2.f_req = 1'b0;
        bus2.d_req = 1'b0;
        @(negedge clk);
        check("idle.status", 64'(st2()), 64'd0);
        check_rdata("idle");
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus2.f_addr = ADDR_W'($urandom);
            bus2.d_addr = ADDR_W'($urandom);
            @(negedge clk);
            check("noreq.status", 64'(st2()), 64'd0);
        end
    endtask

    // Watchdog: every wait in the bench is a fixed cycle count, this only
    // guards against a stalled simulation.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rd1, rd15, dn1, dn15, at1, at15;
        logic        rf, rd, rwe;
        // ---------------- reset ----------------
        rst_n = 1'b0;
        bus2.f_req = 0; bus2.d_req = 0; bus2.d_we = 0;
        bus2.f_addr = '0; bus2.d_addr = '0; bus2.d_wdata = '0;
        bus1.f_req = 0; bus1.d_req = 0; bus1.d_we = 0;
        bus1.f_addr = '0; bus1.d_addr = '0; bus1.d_wdata = '0;
        bus15.f_req = 0; bus15.d_req = 0; bus15.d_we = 0;
        bus15.f_addr = '0; bus15.d_addr = '0; bus15.d_wdata = '0;
        exp_last = 1; exp_f_rdata = '0; exp_d_rdata = '0;
        repeat (2) @(negedge clk);
        check("reset.status", 64'(st2()), 64'd0);
        check("reset.mem_addr", 64'(bus2.mem_addr), 64'd0);
        check("reset.mem_wdata", 64'(bus2.mem_wdata), 64'd0);
        check_rdata("reset");
        rst_n = 1'b1;
        idle_cycles(2);

        // ---------------- contention from reset: F, D, F, D ----------------
        for (int i = 0; i < 4; i++)
            run_txn(1'b1, 1'b1, 1'b0, ADDR_W'(32'h100 + i), ADDR_W'(32'h200 + i),
                    32'h0, 1'b0);

        // ---------------- fetch read of 0x10 ----------------
        run_txn(1'b1, 1'b0, 1'b0, 26'h0000010, 26'h0, 32'h0, 1'b0);
        check("fetch.f_rdata_value", 64'(bus2.f_rdata), 64'h20010005);

        // ---------------- data write, inputs scrambled after grant ----------
        run_txn(1'b0, 1'b1, 1'b1, 26'h0, 26'h03FFFFF, 32'hDEADBEEF, 1'b1);

        // ---------------- data read, then reset in its 2nd ACCESS cycle -----
        run_txn(1'b0, 1'b1, 1'b0, 26'h0, 26'h0000ABC, 32'h0, 1'b0);
        bus2.d_req = 1'b1; bus2.d_we = 1'b0; bus2.d_addr = 26'h0001234;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("rst_mid.pre_status", 64'(st2()), 64'b01_00_10);
        rst_n = 1'b0;
        #1;
        check("rst_mid.status", 64'(st2()), 64'd0);
        check("rst_mid.mem_addr", 64'(bus2.mem_addr), 64'd0);
        exp_last = 1; exp_f_rdata = '0; exp_d_rdata = '0;
        check_rdata("rst_mid");
        bus2.d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(4);
        run_txn(1'b1, 1'b1, 1'b0, 26'h0000777, 26'h0000888, 32'h0, 1'b0);

        // ---------------- random transactions ----------------
        for (int i = 0; i < 40; i++) begin
            rf  = 1'($urandom_range(0, 1));
            rd  = 1'($urandom_range(0, 1));
            rwe = 1'($urandom_range(0, 1));
            if (!rf && !rd) rd = 1'b1;
            run_txn(rf, rd, rwe, ADDR_W'($urandom), ADDR_W'($urandom), $urandom,
                    1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
        end

        // ---------------- WAIT_CYCLES = 1 and 15, request dropped ----------
        rd1 = 0; rd15 = 0; dn1 = 0; dn15 = 0; at1 = 0; at15 = 0;
        bus1.f_req = 1'b1;  bus1.f_addr = 26'h0000155;
        bus15.f_req = 1'b1; bus15.f_addr = 26'h0000155;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                bus1.f_req  = 1'b0;
                bus15.f_req = 1'b0;
            end
            @(negedge clk);
            rd1  += int'(bus1.mem_read);
            rd15 += int'(bus15.mem_read);
            if (bus1.mem_write || bus15.mem_write) begin
                check("wide.no_write", 64'({bus1.mem_write, bus15.mem_write}), 64'd0);
            end
            if (bus1.f_done)  begin dn1++;  at1  = c; end
            if (bus15.f_done) begin dn15++; at15 = c; end
        end
        check("w1.read_width", 64'(rd1), 64'd1);
        check("w15.read_width", 64'(rd15), 64'd15);
        check("w1.done_count", 64'(dn1), 64'd1);
        check("w15.done_count", 64'(dn15), 64'd1);
        check("w1.done_cycle", 64'(at1), 64'd2);
        check("w15.done_cycle", 64'(at15), 64'd16);
        check("w1.f_rdata", 64'(bus1.f_rdata), 64'(mem_fn(26'h0000155)));
        check("w15.f_rdata", 64'(bus15.f_rdata), 64'(mem_fn(26'h0000155)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2: memory access cycles per transaction, legal range 1..15.
REQ-002 The block SHALL have parameter ADDR_W, default 26: width of the word address.
REQ-003 CLK  input  1  single system clock; all state changes on posedge CLK.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 F_REQ  input  1  fetch-side request (requester 0).
REQ-006 F_ADDR  input  ADDR_W  fetch word address; fetch requests are always reads.
REQ-007 F_GNT  output  1  high while a fetch transaction owns the memory port.
REQ-008 F_DONE  output  1  one-cycle pulse: fetch transaction complete, F_RDATA valid.
REQ-009 F_RDATA  output  32  fetch read data, held until the next fetch F_DONE.
REQ-010 D_REQ  input  1  data-side request (requester 1).
REQ-011 D_WE  input  1  data request is a write (1) or a read (0).
REQ-012 D_ADDR  input  ADDR_W  data word address.
REQ-013 D_WDATA  input  32  data write value.
REQ-014 D_GNT  output  1  high while a data transaction owns the memory port.
REQ-015 D_DONE  output  1  one-cycle pulse: data transaction complete, D_RDATA valid on reads.
REQ-016 D_RDATA  output  32  data read value, held until the next data read D_DONE.
REQ-017 MEM_ADDR  output  ADDR_W  address to the shared memory.
REQ-018 MEM_READ  output  1  memory read strobe.
REQ-019 MEM_WRITE  output  1  memory write strobe.
REQ-020 MEM_WDATA  output  32  write data to memory.
REQ-021 MEM_RDATA  input  32  read data from memory, valid in the last access cycle.

Function
REQ-022 The block SHALL implement states IDLE, ACCESS, DONE; IDLE->ACCESS on any sampled request, ACCESS->DONE when the wait counter reaches WAIT_CYCLES-1, DONE->IDLE unconditionally.
REQ-023 In IDLE with exactly one request high, that requester SHALL be granted at the next posedge.
REQ-024 In IDLE with both requests high, the requester not granted last SHALL win (round-robin); the last-grant pointer SHALL update on every grant.
REQ-025 On grant the block SHALL register address, direction and write data; MEM_* outputs SHALL drive from these registers only, never combinationally from requester inputs.
REQ-026 MEM_READ or MEM_WRITE SHALL be high for exactly WAIT_CYCLES cycles (all ACCESS cycles) and low in IDLE and DONE; both SHALL never be high together.
REQ-027 On the last ACCESS cycle of a read, MEM_RDATA SHALL be captured into the owner's RDATA register.
REQ-028 The owner's GNT SHALL be high from the first ACCESS cycle through DONE; the owner's DONE SHALL be high only in the DONE state.
REQ-029 Latency from request sampled in IDLE to DONE pulse SHALL be WAIT_CYCLES+1 cycles; back-to-back transactions SHALL have one IDLE cycle between DONE and the next ACCESS.
REQ-030 A requester deasserting REQ mid-transaction SHALL NOT abort it; the access completes and DONE still pulses.
REQ-031 A request held high through its own DONE SHALL be treated as a new request in the following IDLE cycle.
REQ-032 The wait counter SHALL be 4 bits, clear on entering ACCESS, and never wrap within a transaction.

Reset
REQ-033 RST low SHALL immediately force state IDLE, counter 0, all GNT/DONE/MEM_READ/MEM_WRITE low, MEM_ADDR/MEM_WDATA/F_RDATA/D_RDATA zero.
REQ-034 The last-grant pointer SHALL reset to data, so fetch wins the first contended arbitration.
REQ-035 Reset asserted mid-ACCESS SHALL drop memory strobes asynchronously, with no DONE issued for the aborted transaction.

Structure
REQ-036 State encodings and the WAIT_CYCLES range limits SHALL live in the shared definitions file alongside the processor state constants.
REQ-037 The wait counter SHALL be a sub-module named access_timer (load, enable, terminal-count output).

Verification
REQ-038 Fetch only, F_ADDR=0x0000010, MEM_RDATA=0x20010005 -> MEM_READ high 2 cycles, F_DONE at cycle 3, F_RDATA=0x20010005.
REQ-039 Data write D_ADDR=0x03F_FFFF, D_WDATA=0xDEADBEEF -> MEM_WRITE high 2 cycles with those values, D_DONE pulse, D_RDATA unchanged.
REQ-040 F_REQ and D_REQ high together from reset, held -> grant order fetch, data, fetch, data; one IDLE cycle between each.
REQ-041 RST low in second ACCESS cycle of a data read -> strobes low immediately, no D_DONE, D_RDATA=0, next request served normally.
REQ-042 WAIT_CYCLES=1 and 15 -> MEM_READ width 1 and 15 cycles; F_REQ dropped mid-access still yields F_DONE.
